// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: accepts one load/store, waits WAIT_CYCLES,
// then returns a one-cycle ready strobe with read data and a fault flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        error,
    output logic        busy
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);
    localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [31:0]        eff_addr;
    logic [31:0]        eff_wdata;
    logic               eff_rd;
    logic               eff_wr;
    logic               fault;
    logic               go_resp;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;

    // In IDLE the live inputs are the request (needed when WAIT_CYCLES=0 skips BUSY)
    always_comb begin
        eff_addr  = (state_q == IDLE) ? addr       : addr_q;
        eff_wdata = (state_q == IDLE) ? write_data : wdata_q;
        eff_rd    = (state_q == IDLE) ? MemRead    : rd_q;
        eff_wr    = (state_q == IDLE) ? MemWrite   : wr_q;
        mem_idx   = eff_addr[IDX_W+1:2];
        fault     = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= DEPTH_L)
                    || (eff_rd && eff_wr);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        read_data_d = read_data_q;
        ready_d     = 1'b0;
        error_d     = error_q;
        busy_d      = busy_q;
        go_resp     = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = addr;
                    wdata_d = write_data;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                read_data_d = '0;
                error_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Response is formed on the edge entering RESP
        if (go_resp) begin
            state_d     = RESP;
            cnt_d       = '0;
            ready_d     = 1'b1;
            error_d     = fault;
            read_data_d = (!fault && eff_rd) ? mem_q[mem_idx] : 32'd0;
            mem_we      = !fault && eff_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_idx] <= eff_wdata;
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign busy      = busy_q;

endmodule
